// File: rtl/mult_ctrl_if.sv
// rtl/mult_ctrl_if.sv - CPU-side register bus for the multiplier front end
//
// Signals:
//   cs     peripheral select
//   rd     read strobe, qualified by cs
//   wr     write strobe, qualified by cs
//   addr   byte address of the register
//   d_in   write data
//   d_out  registered read data
// Modports: master = CPU side, slave = peripheral side.
interface mult_ctrl_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [4:0]  addr;
  logic [31:0] d_in;
  logic [31:0] d_out;

  modport master (output cs, rd, wr, addr, d_in, input d_out);
  modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface

// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - register front end for the shift-add multiplier
//
// Holds CPU-written operands, launches the multiplier and captures its
// product on done into a RESULT register with sticky status bits.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   bus          register bus (slave modport): cs/rd/wr/addr/d_in/d_out
//   mult_init    one-cycle start pulse to the multiplier
//   mult_op_A    operand A, driven continuously from OPA
//   mult_op_B    operand B, driven continuously from OPB
//   mult_done    multiplier done level
//   mult_result  multiplier product
module mult_ctrl #(
  parameter int TIMEOUT = 128
) (
  input  logic        clk,
  input  logic        resetn,
  mult_ctrl_if.slave  bus,
  output logic        mult_init,
  output logic [15:0] mult_op_A,
  output logic [15:0] mult_op_B,
  input  logic        mult_done,
  input  logic [31:0] mult_result
);

  localparam int CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_OPA    = 5'h04;
  localparam logic [4:0] A_OPB    = 5'h08;
  localparam logic [4:0] A_RESULT = 5'h0C;
  localparam logic [4:0] A_STATUS = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   opa_q, opa_d;
  logic [15:0]   opb_q, opb_d;
  logic [31:0]   result_q, result_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          tmo_q, tmo_d;
  logic [31:0]   d_out_q, d_out_d;

  logic busy;
  logic rd_en, wr_en;
  logic wr_ctrl, wr_opa, wr_opb;
  logic ovr_set;

  // Upper write-data bits have no register behind them.
  logic unused_d_in;
  assign unused_d_in = ^bus.d_in[31:16];

  assign mult_op_A = opa_q;
  assign mult_op_B = opb_q;
  assign bus.d_out = d_out_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      d_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
      d_out_q  <= d_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    tmo_d     = tmo_q;
    d_out_d   = '0;
    mult_init = 1'b0;

    busy    = (state_q != ST_IDLE);
    rd_en   = bus.cs & bus.rd;
    wr_en   = bus.cs & bus.wr;
    wr_ctrl = wr_en & (bus.addr == A_CTRL);
    wr_opa  = wr_en & (bus.addr == A_OPA);
    wr_opb  = wr_en & (bus.addr == A_OPB);
    ovr_set = busy & ((wr_ctrl & bus.d_in[0]) | wr_opa | wr_opb);

    // Read mux samples the pre-write register values, so a combined
    // rd+wr returns the old contents.
    if (rd_en) begin
      case (bus.addr)
        A_OPA:    d_out_d = {16'h0000, opa_q};
        A_OPB:    d_out_d = {16'h0000, opb_q};
        A_RESULT: d_out_d = result_q;
        A_STATUS: d_out_d = {28'h0, tmo_q, ovr_q, done_q, busy};
        default:  d_out_d = '0;
      endcase
    end

    // Clears are applied before sets below so that a set on the same
    // edge wins.
    if (wr_ctrl & bus.d_in[1]) begin
      ovr_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (rd_en & (bus.addr == A_RESULT)) begin
      done_d = 1'b0;
    end

    // Operands are frozen while a job runs so the multiplier sees
    // stable inputs.
    if (!busy) begin
      if (wr_opa) opa_d = bus.d_in[15:0];
      if (wr_opb) opb_d = bus.d_in[15:0];
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl & bus.d_in[0]) begin
          state_d = ST_LAUNCH;
          done_d  = 1'b0;
        end
      end
      ST_LAUNCH: begin
        mult_init = 1'b1;
        state_d   = ST_WAIT;
        cnt_d     = '0;
      end
      ST_WAIT: begin
        if (mult_done) begin
          state_d  = ST_DRAIN;
          result_d = mult_result;
          done_d   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        // Hold busy until the multiplier drops done and returns to
        // its start state, so a new init is never missed.
        if (!mult_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Memory-mapped front end for the shift-add multiplier peripheral on the femtoRV data bus. It holds the CPU-written 16-bit operands and drives the multiplier's `init`/`op_A`/`op_B`. It captures the 32-bit product on the multiplier's `done` and exposes it through sticky status bits. The CPU never has to race the multiplier's finite `done` window.

## Interface
- `TIMEOUT`, default 128: cycles allowed in WAIT before the job is abandoned.
- `clk`  in  1  system clock, all logic on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `cs`  in  1  peripheral select
- `rd`  in  1  read strobe (qualified by `cs`)
- `wr`  in  1  write strobe (qualified by `cs`)
- `addr`  in  5  byte address: 0x00 CTRL, 0x04 OPA, 0x08 OPB, 0x0C RESULT, 0x10 STATUS
- `d_in`  in  32  write data
- `d_out`  out  32  read data, registered
- `mult_init`  out  1  start pulse to multiplier
- `mult_op_A`  out  16  operand A to multiplier
- `mult_op_B`  out  16  operand B to multiplier
- `mult_done`  in  1  multiplier done level
- `mult_result`  in  32  multiplier product

## Operation
- Registers:
  - OPA and OPB are 16-bit and take `d_in[15:0]`. They read back zero-extended.
  - RESULT is 32-bit and read-only. It holds the last captured product.
  - STATUS bit assignments: [0] busy, [1] done (sticky), [2] overrun (sticky), [3] timeout (sticky). Other bits read 0.
  - CTRL is write-only and reads 0. Bit0 = start. Bit1 = clear overrun and timeout.
- `mult_op_A`/`mult_op_B` are driven continuously from OPA/OPB.
- FSM states: IDLE, LAUNCH, WAIT, DRAIN. `busy` = state != IDLE.
  - IDLE → LAUNCH on a CTRL write with bit0=1. Same edge clears the done flag.
  - LAUNCH: `mult_init`=1 for exactly this cycle, then → WAIT.
  - WAIT → DRAIN when `mult_done`=1. Same edge captures RESULT from `mult_result` and sets done.
  - WAIT → IDLE when the timeout counter reaches TIMEOUT-1 with `mult_done`=0. Sets timeout; RESULT is unchanged.
  - DRAIN → IDLE when `mult_done`=0. The multiplier is then back in START with `init` low.
- The timeout counter clears on entering WAIT and increments each WAIT cycle. It is at least 8 bits wide, sized from TIMEOUT.
- The following accesses while busy are ignored and set overrun; registers are unchanged:
  - a CTRL write with bit0=1;
  - any OPA or OPB write.
- CTRL bit1 is honoured in any state.
- A read of RESULT clears done.
  - If done is set and cleared on the same edge, set wins.
  - Overrun set and clear on the same edge: set wins.
- Unmapped addresses: writes are ignored and reads return 0.
- `rd` and `wr` both high: the write is performed, and `d_out` returns the pre-write register value.

## Timing
- Reset (`resetn`=0, asynchronous): every output and register is 0 and state is IDLE. This covers `mult_init`, `d_out`, OPA, OPB, RESULT and all status bits.
- Read latency: `d_out` is valid on the cycle after the edge sampling `cs&rd`. Otherwise `d_out` is 0 on the next edge.
- Write takes effect at the sampling edge.
- Start latency:
  - The CTRL write edge at cycle 0 enters LAUNCH; `mult_init` is high during cycle 1.
  - The multiplier samples `init` at the end of cycle 1 and latches operands in START1 (cycle 2).
  - Operands are stable throughout, because writes are blocked while busy.
- Done capture: RESULT and the done bit are updated at the first edge where WAIT sees `mult_done`=1.
- Busy spans DRAIN, roughly 31 cycles of the multiplier's hold window. A new start is legal only once STATUS.busy reads 0.
- `resetn` asserted mid-operation returns the FSM to IDLE immediately and forces `mult_init` low.
  - The multiplier has its own reset and is not reset by this block.
  - After deassertion, firmware must not start a job until the multiplier has settled. The minimum wait is 32 cycles.

## Test plan
- Basic job: write OPA=3, OPB=5, CTRL=1, then poll STATUS until bit1 is set. Required: RESULT=0x0000000F. Reading RESULT clears STATUS bit1, and busy falls after `mult_done` drops.
- Full scale: OPA=0xFFFF, OPB=0xFFFF, start. Required: RESULT=0xFFFE0001. Also OPB=0 gives RESULT=0 with done set.
- Overrun: start a job, then write CTRL=1 and OPA=7 while busy. Required:
  - exactly one `mult_init` pulse;
  - `mult_op_A` keeps its original value;
  - STATUS=0x5 (busy and overrun);
  - after CTRL=2, overrun is clear.
- Timeout: model `mult_done` stuck at 0 and start a job. Required: after TIMEOUT+2 cycles STATUS=0x8 and RESULT is unchanged.
- Reset mid-job: assert `resetn`=0 during WAIT. Required: `mult_init`, `d_out` and STATUS read 0 immediately, and the FSM is in IDLE after release.
- Read latency: read OPA after writing 0x1234ABCD. Required: `d_out`=0x0000ABCD exactly one cycle after the `rd` edge, and 0 otherwise.
